gost_mod_sub_iter: RTL and testbench
====================================

// Module: gost_mod_sub_iter
// PURPOSE
//  Iterative modular subtractor: odiff = (ia - ib) mod 2^N, built as a Kogge-Stone
//  prefix tree evaluated one level per clock over a single registered G/P vector.
//  Inverse of the round's mod-2^N adder. Serves the GOST decrypt/key-unwind datapath.
//  Trades latency (log2(N)+1 clocks) for the area of one prefix level.
//  Valid/ready handshake on both sides.
// PARAMETERS
//  N   32  operand width; power of two, 4..64
//  L   $clog2(N)  prefix levels; localparam, not overridable
// PORTS
//  iclk     in   1  clock, all state on rising edge
//  irst_n   in   1  asynchronous active-low reset
//  ivalid   in   1  operands valid
//  oready   out  1  block can accept operands
//  ia       in   N  minuend
//  ib       in   N  subtrahend
//  ovalid   out  1  result valid
//  iready   in   1  downstream accepts result
//  odiff    out  N  (ia - ib) mod 2^N
//  oborrow  out  1  only with GOST_SUB_BORROW_OUT_EN; 1 when ia < ib (unsigned)
// BEHAVIOUR
//  Reset (irst_n=0, async): state=IDLE, level counter=0, G/P regs=0,
//   odiff=0, ovalid=0, oready=0 while in reset, oborrow=0. Operation in flight is dropped.
//  FSM: IDLE -> CALC -> DONE -> IDLE.
//   IDLE: oready=1. ivalid&oready at edge: P<=ia^~ib, P0<=ia^~ib (saved for sum XOR),
//    G<=ia&~ib, with G[0]<=G[0]|P[0] (carry-in 1 folded in); cnt<=0; go CALC.
//   CALC: oready=0. Each edge, level k=cnt: for i>=2^k:
//    G[i]<=G[i]|(P[i]&G[i-2^k]); P[i]<=P[i]&P[i-2^k]; i<2^k unchanged. cnt<=cnt+1.
//    After level L-1 is applied: odiff<=P0^{G[N-2:0],1'b1}; ovalid<=1; go DONE.
//   DONE: ovalid=1, odiff stable until iready=1 at an edge; then ovalid<=0, go IDLE.
//  Latency: ovalid rises L+1 edges after the accepting edge (N=32: 6 clocks).
//  Throughput: one operation per L+3 clocks; oready is 0 in CALC and DONE.
//  Accept-then-drain: no new operand accepted in the cycle iready completes DONE.
//  ia/ib sampled only at the accepting edge; later changes ignored.
//  ivalid outside IDLE ignored (source must hold until oready).
//  Wrap-around: ia<ib wraps mod 2^N, e.g. 0-1 = all ones; no error signalled.
//  cnt width $clog2(L)+1; must not wrap before reaching L-1.
// CONFIGURATION
//  GOST_SUB_BORROW_OUT_EN defined: port oborrow present; registered with odiff as
//   ~G[N-1] (final level); held in DONE; reset 0.
//  Undefined: no oborrow port, no extra register; all other behaviour identical.
// TESTING
//  N=32, ia=5, ib=3, iready=1 -> odiff=0x00000002 6 clocks after accept, oborrow=0.
//  ia=0, ib=1 -> odiff=0xFFFFFFFF, oborrow=1; ia=ib=0xA5A5A5A5 -> odiff=0, oborrow=0.
//  ia=0x80000000, ib=0x00000001 -> 0x7FFFFFFF (full carry chain through all levels).
//  Backpressure: iready=0 for 10 clocks in DONE -> ovalid/odiff held, oready=0, new
//   ivalid ignored; iready=1 -> ovalid drops next edge, oready=1 following cycle.
//  irst_n pulsed low mid-CALC -> all outputs 0 immediately; next op 7-4 gives 3.
//  Random 10k pairs, random ivalid/iready -> odiff matches (ia-ib) mod 2^32 in order.

Source files
------------

// File: rtl/gost_mod_sub_iter_if.sv
// Operand/result handshake bundle for gost_mod_sub_iter.
// oborrow exists only when GOST_SUB_BORROW_OUT_EN is defined.
interface gost_mod_sub_iter_if #(
    parameter int N = 32
);
    logic         ivalid;
    logic         oready;
    logic [N-1:0] ia;
    logic [N-1:0] ib;
    logic         ovalid;
    logic         iready;
    logic [N-1:0] odiff;
`ifdef GOST_SUB_BORROW_OUT_EN
    logic         oborrow;
`endif

    modport master (
        output ivalid, ia, ib, iready,
`ifdef GOST_SUB_BORROW_OUT_EN
        input  oborrow,
`endif
        input  oready, ovalid, odiff
    );

    modport slave (
        input  ivalid, ia, ib, iready,
`ifdef GOST_SUB_BORROW_OUT_EN
        output oborrow,
`endif
        output oready, ovalid, odiff
    );
endinterface

// File: rtl/gost_mod_sub_iter.sv
// Iterative mod-2^N subtractor: one Kogge-Stone prefix level per clock.
// Optional oborrow output enabled by GOST_SUB_BORROW_OUT_EN.
module gost_mod_sub_iter #(
    parameter int N = 32
) (
    input  logic                iclk,
    input  logic                irst_n,
    gost_mod_sub_iter_if.slave  bus
);
    localparam int L  = $clog2(N);
    localparam int CW = $clog2(L) + 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [N-1:0]  g;
    logic [N-1:0]  p;
    logic [N-1:0]  p0;
    logic [N-1:0]  g_nxt;
    logic [N-1:0]  p_nxt;
    logic [N-1:0]  p_in;
    logic [N-1:0]  g_in;
    logic [N-1:0]  diff;
    logic          valid;
    logic          ready;
`ifdef GOST_SUB_BORROW_OUT_EN
    logic          borrow;
`endif

    // a - b computed as a + ~b + 1
    assign p_in = bus.ia ^ ~bus.ib;
    assign g_in = (bus.ia & ~bus.ib) | {{(N-1){1'b0}}, p_in[0]};

    always_comb begin
        g_nxt = g;
        p_nxt = p;
        for (int k = 0; k < L; k++) begin
            if (cnt == CW'(k)) begin
                for (int i = 2**k; i < N; i++) begin
                    g_nxt[i] = g[i] | (p[i] & g[i-2**k]);
                    p_nxt[i] = p[i] & p[i-2**k];
                end
            end
        end
    end

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            g      <= '0;
            p      <= '0;
            p0     <= '0;
            diff   <= '0;
            valid  <= 1'b0;
            ready  <= 1'b0;
`ifdef GOST_SUB_BORROW_OUT_EN
            borrow <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    ready <= 1'b1;
                    if (bus.ivalid && ready) begin
                        p     <= p_in;
                        p0    <= p_in;
                        g     <= g_in;
                        cnt   <= '0;
                        ready <= 1'b0;
                        state <= CALC;
                    end
                end
                CALC: begin
                    // final pass turns the fully resolved carries into the result
                    if (cnt == CW'(L)) begin
                        diff  <= p0 ^ {g[N-2:0], 1'b1};
                        valid <= 1'b1;
`ifdef GOST_SUB_BORROW_OUT_EN
                        borrow <= ~g[N-1];
`endif
                        state <= DONE;
                    end else begin
                        g   <= g_nxt;
                        p   <= p_nxt;
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.iready) begin
                        valid <= 1'b0;
                        ready <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.odiff  = diff;
    assign bus.ovalid = valid;
    assign bus.oready = ready;
`ifdef GOST_SUB_BORROW_OUT_EN
    assign bus.oborrow = borrow;
`endif
endmodule

// File: tb/tb_gost_mod_sub_iter.sv
// Directed-vector bench for gost_mod_sub_iter (N=32).
// Borrow checks active when GOST_SUB_BORROW_OUT_EN is defined.
module tb_gost_mod_sub_iter;
    localparam int N = 32;
    localparam int LAT = 6;

    logic iclk;
    logic irst_n;
    int   checks;
    int   errors;

    gost_mod_sub_iter_if #(.N(N)) bus ();

    gost_mod_sub_iter #(.N(N)) dut (
        .iclk  (iclk),
        .irst_n(irst_n),
        .bus   (bus.slave)
    );

    initial iclk = 1'b0;
    always #5 iclk = ~iclk;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] d;
        logic         br;
        int           hold;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge iclk);
        #1;
    endtask

    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [N-1:0] d, input logic br, input int hold);
        int n;
        n = 0;
        while (!bus.oready && n < 20) begin
            tick();
            n++;
        end
        chk("oready_wait", 64'(bus.oready), 64'd1);
        bus.ivalid = 1'b1;
        bus.ia     = a;
        bus.ib     = b;
        bus.iready = (hold == 0);
        tick();
        bus.ivalid = 1'b0;
        bus.ia     = $urandom;
        bus.ib     = $urandom;
        n = 0;
        while (!bus.ovalid && n < 20) begin
            tick();
            n++;
        end
        chk("latency", 64'(n), 64'(LAT));
        chk("odiff", 64'(bus.odiff), 64'(d));
`ifdef GOST_SUB_BORROW_OUT_EN
        chk("oborrow", 64'(bus.oborrow), 64'(br));
`endif
        if (hold > 0) begin
            bus.ivalid = 1'b1;
            repeat (hold) tick();
            chk("held_ovalid", 64'(bus.ovalid), 64'd1);
            chk("held_odiff", 64'(bus.odiff), 64'(d));
            chk("held_oready", 64'(bus.oready), 64'd0);
            bus.ivalid = 1'b0;
            bus.iready = 1'b1;
        end
        tick();
        chk("drop_ovalid", 64'(bus.ovalid), 64'd0);
        chk("drop_oready", 64'(bus.oready), 64'd1);
    endtask

    initial begin
        logic [N-1:0] ra;
        logic [N-1:0] rb;
        checks     = 0;
        errors     = 0;
        bus.ivalid = 1'b0;
        bus.ia     = '0;
        bus.ib     = '0;
        bus.iready = 1'b1;
        irst_n     = 1'b0;

        vecs[0] = '{32'h00000005, 32'h00000003, 32'h00000002, 1'b0, 0};
        vecs[1] = '{32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b1, 0};
        vecs[2] = '{32'hA5A5A5A5, 32'hA5A5A5A5, 32'h00000000, 1'b0, 0};
        vecs[3] = '{32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 0};
        vecs[4] = '{32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 1'b0, 0};
        vecs[5] = '{32'h00000000, 32'hFFFFFFFF, 32'h00000001, 1'b1, 2};
        vecs[6] = '{32'h12345678, 32'h87654321, 32'h8ACF1357, 1'b1, 0};
        vecs[7] = '{32'h87654321, 32'h12345678, 32'h7530ECA9, 1'b0, 10};
        vecs[8] = '{32'h00000007, 32'h00000004, 32'h00000003, 1'b0, 0};

        repeat (2) tick();
        chk("rst_ovalid", 64'(bus.ovalid), 64'd0);
        chk("rst_oready", 64'(bus.oready), 64'd0);
        chk("rst_odiff", 64'(bus.odiff), 64'd0);
        irst_n = 1'b1;

        for (int i = 0; i < 9; i++)
            run_op(vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].br, vecs[i].hold);

        // no phantom operation after a backpressured drain
        repeat (8) tick();
        chk("idle_ovalid", 64'(bus.ovalid), 64'd0);

        // reset pulse mid-CALC drops the operation
        bus.ivalid = 1'b1;
        bus.ia     = 32'hDEADBEEF;
        bus.ib     = 32'h00000001;
        tick();
        bus.ivalid = 1'b0;
        tick();
        tick();
        irst_n = 1'b0;
        #1;
        chk("midrst_ovalid", 64'(bus.ovalid), 64'd0);
        chk("midrst_oready", 64'(bus.oready), 64'd0);
        chk("midrst_odiff", 64'(bus.odiff), 64'd0);
`ifdef GOST_SUB_BORROW_OUT_EN
        chk("midrst_oborrow", 64'(bus.oborrow), 64'd0);
`endif
        tick();
        irst_n = 1'b1;
        run_op(32'd7, 32'd4, 32'd3, 1'b0, 0);

        for (int i = 0; i < 150; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 7 == 0) rb = ra + 32'd1;
            run_op(ra, rb, ra - rb, ra < rb, int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
